led_bin2ascii: RTL and testbench
================================

# led_bin2ascii

Binary-to-ASCII decimal converter that feeds the 4-digit 7-segment display driver. The CPU-side peripheral logic writes a 16-bit unsigned value. The block converts it to four ASCII decimal digit bytes using a sequential shift-and-add-3 (double-dabble) engine and holds the result on registered outputs. Those outputs wire directly to the display driver's four digit inputs. The block optionally blanks leading zeros and saturates values above 9999.

## Interface
- DIGITS, 4, number of decimal digits produced (fixed at 4; other values unsupported)
- BLANK_CHAR, 8'h20, ASCII byte emitted for a blanked digit (the display driver shows any non-digit byte as all segments off)
- Clk  input  1  system clock, all state on rising edge
- Rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe, one cycle; accepted only when busy=0
- wr_data  input  16  unsigned binary value to display
- blank_lz  input  1  leading-zero blanking enable, sampled with wr_en
- busy  output  1  conversion in progress; writes ignored while high
- ovf  output  1  last accepted value exceeded 9999 and was saturated
- digit1  output  8  ASCII ones digit (rightmost)
- digit2  output  8  ASCII tens digit
- digit3  output  8  ASCII hundreds digit
- digit4  output  8  ASCII thousands digit (leftmost)

## Operation
- One clock (Clk); reset is asynchronous and active-low (Rst_n).
- Reset values: busy=0, ovf=0, digit1..digit4=8'h30 ("0000"), FSM=IDLE, iteration counter=0, BCD scratch=0.
- FSM states and transitions:
  - IDLE -> SHIFT on wr_en=1.
  - SHIFT -> SHIFT while counter<13.
  - SHIFT -> DONE at counter=13, i.e. after 14 shift iterations.
  - DONE -> IDLE unconditionally.
- Capture on acceptance:
  - Value v = (wr_data > 9999) ? 9999 : wr_data[13:0], held in a 14-bit shift register.
  - ovf <= (wr_data > 9999).
  - blank_lz is latched.
  - BCD scratch (16 bits) cleared; counter cleared; busy <= 1.
- SHIFT iteration, one per cycle:
  - Each BCD nibble >= 5 gets +3 (4-bit add, no carry between nibbles).
  - Then {bcd, bin} shifts left by 1.
  - counter increments.
- DONE:
  - Each nibble n maps to ASCII 8'h30+n, giving digit1=ones through digit4=thousands.
  - If latched blank_lz=1, digit4 becomes BLANK_CHAR when its nibble is 0.
  - digit3 is blanked if 0 and digit4 blanked; digit2 is blanked if 0 and digit3 blanked.
  - digit1 is never blanked.
  - busy <= 0.
- Outputs change only in DONE, all four digits on the same edge. The display never shows a partially converted value.
- wr_en while busy=1 is dropped silently: no queueing and no effect on ovf or digits.
- ovf stays valid until the next accepted write.
- Reset asserted mid-conversion aborts immediately. All outputs return to reset values and no partial result is ever written.

## Timing
- Edge E0: wr_en=1 and busy=0 sampled; capture; busy=1 visible after E0.
- Edges E1..E14: 14 SHIFT iterations.
- Edge E15: DONE; digits and busy=0 update together.
- Latency from write to new digits: 15 clocks. Busy is high for 15 cycles.
- Earliest next accepted write: E16. wr_en at E15 is ignored because busy is still 1 when sampled.
- ovf updates at E0 (capture), not at E15.
- Output paths are register-only; no combinational path from wr_data/wr_en to any output.
- Throughput: one conversion per 16 clocks. At 50 MHz this is far faster than the display driver's ~5001-clock digit refresh, so no display tearing is possible.

## Test plan
- Reset check: assert Rst_n=0 -> busy=0, ovf=0, digit4..digit1 = 30,30,30,30 hex.
- Write 1234, blank_lz=0 -> busy high for exactly 15 cycles; at E15 digits (4..1) = 31,32,33,34 and ovf=0.
- Write 7, blank_lz=1 -> digits = 20,20,20,37. Write 0, blank_lz=1 -> 20,20,20,30. Write 1005, blank_lz=1 -> 31,30,30,35 (interior zeros kept).
- Write 10000, then 65535 -> ovf=1 after E0; digits = 39,39,39,39. Subsequent write 42 with blank_lz=0 -> ovf=0, digits 30,30,34,32.
- Write 1234, then wr_en with 5678 at E5 and at E15 -> both ignored; result 1234. A write at E16 is accepted -> 35,36,37,38 at E16+15.
- Prior value 9876 displayed; write 1111 then drop Rst_n at E7 -> outputs immediately at reset values. After release no spurious DONE: digits stay 30,30,30,30 and busy=0.

Source files
------------

// File: rtl/led_bin2ascii.sv
// rtl/led_bin2ascii.sv - 16-bit binary to 4-digit ASCII decimal converter (double-dabble)
module led_bin2ascii #(
    parameter int          DIGITS     = 4,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        blank_lz,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  digit3,
    output logic [7:0]  digit4
);

    localparam int          BCD_W     = 4 * DIGITS;
    localparam logic [3:0]  LAST_ITER = 4'd13;
    localparam logic [15:0] MAX_VAL   = 16'd9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [13:0]        bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               blz_q, blz_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        dig_q, dig_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [31:0]        ascii;
    logic               over;
    logic [13:0]        sat_val;
    logic               blank4, blank3, blank2;

    assign over    = (wr_data > MAX_VAL);
    assign sat_val = over ? MAX_VAL[13:0] : wr_data[13:0];

    // Add-3 correction per nibble, no carry between nibbles.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Blanking ripples from the leftmost digit; the ones digit always shows.
    always_comb begin
        blank4 = blz_q && (bcd_q[15:12] == 4'd0);
        blank3 = blank4 && (bcd_q[11:8] == 4'd0);
        blank2 = blank3 && (bcd_q[7:4] == 4'd0);
        ascii[7:0]   = {4'h3, bcd_q[3:0]};
        ascii[15:8]  = blank2 ? BLANK_CHAR : {4'h3, bcd_q[7:4]};
        ascii[23:16] = blank3 ? BLANK_CHAR : {4'h3, bcd_q[11:8]};
        ascii[31:24] = blank4 ? BLANK_CHAR : {4'h3, bcd_q[15:12]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        blz_d   = blz_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    state_d = ST_SHIFT;
                    bin_d   = sat_val;
                    ovf_d   = over;
                    blz_d   = blank_lz;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                dig_d   = ascii;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            blz_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= 32'h3030_3030;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            blz_q   <= blz_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
        end
    end

    assign busy   = busy_q;
    assign ovf    = ovf_q;
    assign digit1 = dig_q[7:0];
    assign digit2 = dig_q[15:8];
    assign digit3 = dig_q[23:16];
    assign digit4 = dig_q[31:24];

endmodule

// File: tb/tb_led_bin2ascii.sv
// tb/tb_led_bin2ascii.sv - scoreboard bench for led_bin2ascii with a decimal reference model
module tb_led_bin2ascii;

    logic        Clk;
    logic        Rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        blank_lz;
    logic        busy;
    logic        ovf;
    logic [7:0]  digit1, digit2, digit3, digit4;

    typedef struct {
        logic [31:0] digits;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    led_bin2ascii #(.DIGITS(4), .BLANK_CHAR(8'h20)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .blank_lz (blank_lz),
        .busy     (busy),
        .ovf      (ovf),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .digit4   (digit4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal digits via division, leading zeros replaced by spaces.
    function automatic exp_t model(input int d, input bit blz);
        exp_t        e;
        int          v;
        int          dig[4];
        bit          lead;
        logic [7:0]  c;
        v      = (d > 9999) ? 9999 : d;
        e.ovf  = (d > 9999);
        dig[0] = v % 10;
        dig[1] = (v / 10) % 10;
        dig[2] = (v / 100) % 10;
        dig[3] = v / 1000;
        lead   = blz;
        e.digits = '0;
        for (int i = 3; i >= 0; i--) begin
            if (lead && dig[i] == 0 && i > 0) begin
                c = 8'h20;
            end else begin
                c = 8'h30 + 8'(dig[i]);
                lead = 1'b0;
            end
            e.digits[i*8 +: 8] = c;
        end
        return e;
    endfunction

    // Monitor: ovf checked at conversion start, digits and busy width at completion.
    logic prev_busy = 1'b0;
    int   bcnt      = 0;
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst_n) begin
            prev_busy = 1'b0;
            bcnt      = 0;
        end else begin
            if (busy && !prev_busy) begin
                bcnt = 0;
                if (exp_q.size() > 0) chk("ovf_after_capture", {31'd0, ovf}, {31'd0, exp_q[0].ovf});
                else chk("unexpected_start", 32'd1, 32'd0);
            end
            if (busy) bcnt++;
            if (!busy && prev_busy) begin
                chk("busy_width", bcnt, 32'd15);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("digits", {digit4, digit3, digit2, digit1}, e.digits);
                    chk("ovf_hold", {31'd0, ovf}, {31'd0, e.ovf});
                end else begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic write(input int d, input bit blz);
        wait_idle();
        wr_en    = 1'b1;
        wr_data  = 16'(d);
        blank_lz = blz;
        exp_q.push_back(model(d, blz));
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    task automatic poke(input int d);
        wr_en   = 1'b1;
        wr_data = 16'(d);
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    initial begin
        int sel;
        int d;
        Rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        chk("reset_digits", {digit4, digit3, digit2, digit1}, 32'h3030_3030);
        Rst_n = 1'b1;
        @(negedge Clk);

        write(1234, 1'b0);
        write(7, 1'b1);
        write(0, 1'b1);
        write(1005, 1'b1);
        write(10000, 1'b0);
        write(65535, 1'b1);
        write(42, 1'b0);
        write(9999, 1'b1);

        // Writes at E5 and E15 must be dropped; E16 is accepted.
        write(1234, 1'b0);
        repeat (4) @(negedge Clk);
        poke(5678);
        repeat (9) @(negedge Clk);
        chk("busy_at_e15_sample", {31'd0, busy}, 32'd1);
        poke(5678);
        write(5678, 1'b0);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       d = 0;
                1:       d = 9999;
                2:       d = 10000;
                3:       d = $urandom_range(0, 9999);
                4:       d = int'($urandom & 32'hFFFF);
                default: d = $urandom_range(0, 99);
            endcase
            write(d, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        // Reset mid-conversion aborts without a result.
        write(9876, 1'b0);
        write(1111, 1'b0);
        repeat (6) @(negedge Clk);
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        chk("abort_digits", {digit4, digit3, digit2, digit1}, 32'h3030_3030);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (30) @(negedge Clk);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_digits", {digit4, digit3, digit2, digit1}, 32'h3030_3030);

        write(42, 1'b1);
        wait_idle();
        @(negedge Clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
